// File: rtl/pixel_fb_pkg.sv
// Shared types, default widths and helper functions for the pixel framebuffer writer.
package pixel_fb_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int COLOR_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCEPT = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Fields follow the package default widths.
    typedef struct packed {
        logic [COLOR_W_DEF-1:0] color;
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic                   draw;
    } pixel_beat_t;

    // Increment that sticks at max_val; narrower counters pass their own all-ones.
    function automatic logic [23:0] sat_inc(input logic [23:0] val, input logic [23:0] max_val);
        logic [23:0] res;
        if (val >= max_val) begin
            res = max_val;
        end else begin
            res = val + 24'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Two-stage y*width+x address pipeline feeding the registered framebuffer write port;
// clear words bypass the pipeline straight into the write register.
module fb_addr_gen
    import pixel_fb_pkg::*;
#(
    parameter int                 COORD_W     = COORD_W_DEF,
    parameter int                 COLOR_W     = COLOR_W_DEF,
    parameter int                 FB_ADDR_W   = 21,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = {COLOR_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_in,
    input  logic [COORD_W-1:0]   pix_x,
    input  logic [COORD_W-1:0]   pix_y,
    input  logic [COLOR_W-1:0]   pix_color,
    input  logic [COORD_W-1:0]   width,
    input  logic                 clr_load,
    input  logic [FB_ADDR_W-1:0] clr_addr,
    output logic                 s1_valid,
    output logic                 wr_en,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [COLOR_W-1:0]   wr_data
);

    logic                   s1_valid_r;
    logic [COORD_W-1:0]     s1_x_r;
    logic [COLOR_W-1:0]     s1_color_r;
    logic [2*COORD_W-1:0]   s1_prod_r;
    logic                   wr_en_r;
    logic [FB_ADDR_W-1:0]   wr_addr_r;
    logic [COLOR_W-1:0]     wr_data_r;

    // Stage 1: capture the beat and the row offset y*width.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= {COORD_W{1'b0}};
            s1_color_r <= {COLOR_W{1'b0}};
            s1_prod_r  <= {(2*COORD_W){1'b0}};
        end else begin
            s1_valid_r <= pix_in;
            s1_x_r     <= pix_x;
            s1_color_r <= pix_color;
            s1_prod_r  <= {{COORD_W{1'b0}}, pix_y} * {{COORD_W{1'b0}}, width};
        end
    end

    // Stage 2: write port register; clear words and pixel writes never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {FB_ADDR_W{1'b0}};
            wr_data_r <= {COLOR_W{1'b0}};
        end else if (clr_load) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= clr_addr;
            wr_data_r <= CLEAR_COLOR;
        end else if (s1_valid_r) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= FB_ADDR_W'(s1_prod_r + {{COORD_W{1'b0}}, s1_x_r});
            wr_data_r <= s1_color_r;
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
        end
    end

    assign s1_valid = s1_valid_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;

endmodule

// File: rtl/pixel_fb_writer.sv
// Framebuffer writer: clears the frame, then writes drawn pixels to y*width+x.
// Optional FB_DOUBLE_BUFFER_EN adds a bank MSB on fb_wr_addr and a disp_bank output.
module pixel_fb_writer
    import pixel_fb_pkg::*;
#(
    parameter int                 COORD_W     = COORD_W_DEF,
    parameter int                 COLOR_W     = COLOR_W_DEF,
    parameter int                 FB_ADDR_W   = 21,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [COLOR_W-1:0]   pix_color,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [COORD_W-1:0]   pix_x,
    input  logic [COORD_W-1:0]   pix_y,
    input  logic                 pix_draw,
    input  logic [COORD_W-1:0]   fb_width,
    input  logic [COORD_W-1:0]   fb_height,
    input  logic                 gpu_frame_end,
    output logic                 fb_wr_en,
`ifdef FB_DOUBLE_BUFFER_EN
    output logic [FB_ADDR_W:0]   fb_wr_addr,
    output logic                 disp_bank,
`else
    output logic [FB_ADDR_W-1:0] fb_wr_addr,
`endif
    output logic [COLOR_W-1:0]   fb_wr_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          oob_count,
    output logic [23:0]          px_count
);

    state_t                 state_r;
    state_t                 state_next;
    logic [COORD_W-1:0]     width_r;
    logic [COORD_W-1:0]     height_r;
    logic [FB_ADDR_W-1:0]   total_r;
    logic [FB_ADDR_W-1:0]   clr_addr_r;
    logic                   frame_end_d_r;
    logic                   fe_seen_r;
    logic                   pix_ready_r;
    logic                   busy_r;
    logic                   frame_done_r;
    logic [15:0]            oob_count_r;
    logic [23:0]            px_count_r;

    logic                   latch_s;
    logic                   clr_load_s;
    logic [FB_ADDR_W-1:0]   clr_next_s;
    logic                   fe_rise_s;
    logic                   accept_s;
    logic                   in_bounds_s;
    logic                   pipe_in_s;
    logic                   oob_hit_s;
    logic                   s1_valid_s;
    logic [FB_ADDR_W-1:0]   wr_addr_s;
    pixel_beat_t            beat_s;

    assign beat_s      = '{color: pix_color, x: pix_x, y: pix_y, draw: pix_draw};
    assign fe_rise_s   = gpu_frame_end & ~frame_end_d_r;
    assign accept_s    = pix_valid & pix_ready_r;
    assign in_bounds_s = (beat_s.x < width_r) && (beat_s.y < height_r);
    assign pipe_in_s   = accept_s & beat_s.draw & in_bounds_s;
    assign oob_hit_s   = accept_s & beat_s.draw & ~in_bounds_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic; clear addresses are issued so each word is on the port while in CLEAR.
    always_comb begin
        state_next = state_r;
        latch_s    = 1'b0;
        clr_load_s = 1'b0;
        clr_next_s = {FB_ADDR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    latch_s = 1'b1;
                    if ((fb_width == {COORD_W{1'b0}}) || (fb_height == {COORD_W{1'b0}})) begin
                        state_next = ST_ACCEPT;
                    end else begin
                        state_next = ST_CLEAR;
                        clr_load_s = 1'b1;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_r == (total_r - {{(FB_ADDR_W-1){1'b0}}, 1'b1})) begin
                    if (fe_seen_r || fe_rise_s) begin
                        state_next = ST_DRAIN;
                    end else begin
                        state_next = ST_ACCEPT;
                    end
                end else begin
                    clr_load_s = 1'b1;
                    clr_next_s = clr_addr_r + {{(FB_ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_ACCEPT: begin
                if (fe_rise_s) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_ACCEPT;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_s) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame geometry and clear bookkeeping, captured once per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            width_r    <= {COORD_W{1'b0}};
            height_r   <= {COORD_W{1'b0}};
            total_r    <= {FB_ADDR_W{1'b0}};
            clr_addr_r <= {FB_ADDR_W{1'b0}};
        end else begin
            if (latch_s) begin
                width_r  <= fb_width;
                height_r <= fb_height;
                total_r  <= FB_ADDR_W'({{COORD_W{1'b0}}, fb_width} * {{COORD_W{1'b0}}, fb_height});
            end
            if (clr_load_s) begin
                clr_addr_r <= clr_next_s;
            end
        end
    end

    // Frame-end edge detection; a rise seen during the clear is held until it ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_end_d_r <= 1'b1;
            fe_seen_r     <= 1'b0;
        end else begin
            frame_end_d_r <= gpu_frame_end;
            if (latch_s) begin
                fe_seen_r <= 1'b0;
            end else if ((state_r == ST_CLEAR) && fe_rise_s) begin
                fe_seen_r <= 1'b1;
            end
        end
    end

    // Status outputs, registered from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            pix_ready_r  <= (state_next == ST_ACCEPT);
            busy_r       <= (state_next != ST_IDLE);
            frame_done_r <= (state_next == ST_DONE);
        end
    end

    // Per-frame counters; pixel writes are counted as they leave stage 1.
    always_ff @(posedge clk) begin
        if (reset || latch_s) begin
            oob_count_r <= 16'h0000;
            px_count_r  <= 24'h000000;
        end else begin
            if (oob_hit_s) begin
                oob_count_r <= 16'(sat_inc({8'h00, oob_count_r}, 24'h00FFFF));
            end
            if (s1_valid_s) begin
                px_count_r <= sat_inc(px_count_r, 24'hFFFFFF);
            end
        end
    end

    fb_addr_gen #(
        .COORD_W     (COORD_W),
        .COLOR_W     (COLOR_W),
        .FB_ADDR_W   (FB_ADDR_W),
        .CLEAR_COLOR (CLEAR_COLOR)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pipe_in_s),
        .pix_x     (beat_s.x),
        .pix_y     (beat_s.y),
        .pix_color (beat_s.color),
        .width     (width_r),
        .clr_load  (clr_load_s),
        .clr_addr  (clr_next_s),
        .s1_valid  (s1_valid_s),
        .wr_en     (fb_wr_en),
        .wr_addr   (wr_addr_s),
        .wr_data   (fb_wr_data)
    );

`ifdef FB_DOUBLE_BUFFER_EN
    logic draw_bank_r;
    logic disp_bank_r;

    // Swap draw/display banks as each frame completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            draw_bank_r <= 1'b0;
            disp_bank_r <= 1'b1;
        end else if (state_r == ST_DONE) begin
            draw_bank_r <= ~draw_bank_r;
            disp_bank_r <= ~disp_bank_r;
        end else begin
            draw_bank_r <= draw_bank_r;
            disp_bank_r <= disp_bank_r;
        end
    end

    assign fb_wr_addr = {draw_bank_r, wr_addr_s};
    assign disp_bank  = disp_bank_r;
`else
    assign fb_wr_addr = wr_addr_s;
`endif

    assign pix_ready  = pix_ready_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign oob_count  = oob_count_r;
    assign px_count   = px_count_r;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed self-checking bench for pixel_fb_writer; also covers FB_DOUBLE_BUFFER_EN when defined.
module tb_pixel_fb_writer;

    localparam int COORD_W   = 11;
    localparam int COLOR_W   = 8;
    localparam int FB_ADDR_W = 21;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 frame_start;
    logic [COLOR_W-1:0]   pix_color;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [COORD_W-1:0]   pix_x;
    logic [COORD_W-1:0]   pix_y;
    logic                 pix_draw;
    logic [COORD_W-1:0]   fb_width;
    logic [COORD_W-1:0]   fb_height;
    logic                 gpu_frame_end;
    logic                 fb_wr_en;
`ifdef FB_DOUBLE_BUFFER_EN
    logic [FB_ADDR_W:0]   fb_wr_addr;
    logic                 disp_bank;
`else
    logic [FB_ADDR_W-1:0] fb_wr_addr;
`endif
    logic [COLOR_W-1:0]   fb_wr_data;
    logic                 busy;
    logic                 frame_done;
    logic [15:0]          oob_count;
    logic [23:0]          px_count;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_bank = 1'b0;
    int   done_cnt;
    int   other_cnt;

    always #5 clk = ~clk;

    pixel_fb_writer dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .pix_color     (pix_color),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_draw      (pix_draw),
        .fb_width      (fb_width),
        .fb_height     (fb_height),
        .gpu_frame_end (gpu_frame_end),
        .fb_wr_en      (fb_wr_en),
        .fb_wr_addr    (fb_wr_addr),
`ifdef FB_DOUBLE_BUFFER_EN
        .disp_bank     (disp_bank),
`endif
        .fb_wr_data    (fb_wr_data),
        .busy          (busy),
        .frame_done    (frame_done),
        .oob_count     (oob_count),
        .px_count      (px_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input int addr, input logic [7:0] data);
        check({tag, "_en"}, 32'(fb_wr_en), 32'd1);
        check({tag, "_addr"}, 32'(fb_wr_addr[FB_ADDR_W-1:0]), 32'(addr));
        check({tag, "_data"}, 32'(fb_wr_data), 32'(data));
`ifdef FB_DOUBLE_BUFFER_EN
        check({tag, "_bank"}, 32'(fb_wr_addr[FB_ADDR_W]), 32'(exp_bank));
`endif
    endtask

    task automatic drive_beat(input logic v, input int x, input int y, input logic [7:0] c, input logic d);
        pix_valid = v;
        pix_x     = 11'(x);
        pix_y     = 11'(y);
        pix_color = c;
        pix_draw  = d;
    endtask

    // Wait a fixed window, counting frame_done pulses and a second signal of interest.
    task automatic watch_done(input int cycles, input bit watch_wr);
        done_cnt  = 0;
        other_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (frame_done) done_cnt++;
            if (watch_wr ? fb_wr_en : pix_ready) other_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; gpu_frame_end = 1'b1;
        fb_width = 11'd4; fb_height = 11'd2;
        drive_beat(1'b0, 0, 0, 8'h00, 1'b0);
        tick(); tick();
        check("rst_ready", 32'(pix_ready), 32'd0);
        check("rst_wr_en", 32'(fb_wr_en), 32'd0);
        check("rst_addr", 32'(fb_wr_addr), 32'd0);
        check("rst_data", 32'(fb_wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_oob", 32'(oob_count), 32'd0);
        check("rst_px", 32'(px_count), 32'd0);
`ifdef FB_DOUBLE_BUFFER_EN
        check("rst_disp_bank", 32'(disp_bank), 32'd1);
`endif
        reset = 1'b0;
        tick();

        // Frame A: 4x2 clear, 8 words at 0..7
        frame_start = 1'b1; gpu_frame_end = 1'b0;
        tick();
        frame_start = 1'b0;
        check("a_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_wr("a_clr", i, 8'h00);
            check("a_clr_ready", 32'(pix_ready), 32'd0);
            tick();
        end
        check("a_post_clr_en", 32'(fb_wr_en), 32'd0);
        check("a_post_clr_ready", 32'(pix_ready), 32'd1);

        // Single beat (3,1) -> address 7 two cycles later
        drive_beat(1'b1, 3, 1, 8'hAB, 1'b1);
        tick();
        drive_beat(1'b0, 0, 0, 8'h00, 1'b0);
        check("a_lat_t1", 32'(fb_wr_en), 32'd0);
        tick();
        check_wr("a_pix", 7, 8'hAB);
        check("a_px1", 32'(px_count), 32'd1);
        tick();

        // Two out-of-bounds drawn beats and one undrawn beat
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive_beat(1'b1, 4, 0, 8'h11, 1'b1);
                1:       drive_beat(1'b1, 0, 2, 8'h22, 1'b1);
                default: drive_beat(1'b1, 1, 1, 8'h33, 1'b0);
            endcase
            tick();
            check("a_nowr", 32'(fb_wr_en), 32'd0);
        end
        drive_beat(1'b0, 0, 0, 8'h00, 1'b0);
        tick();
        check("a_nowr_d1", 32'(fb_wr_en), 32'd0);
        tick();
        check("a_nowr_d2", 32'(fb_wr_en), 32'd0);
        check("a_oob2", 32'(oob_count), 32'd2);
        check("a_px_still1", 32'(px_count), 32'd1);

        // Burst of 8 beats; frame_end rises with the last beat
        for (int c = 0; c < 9; c++) begin
            if (c < 8) begin
                drive_beat(1'b1, c % 4, c / 4, 8'(8'h10 + c), 1'b1);
                check("burst_ready", 32'(pix_ready), 32'd1);
            end else begin
                drive_beat(1'b0, 0, 0, 8'h00, 1'b0);
            end
            if (c == 7) gpu_frame_end = 1'b1;
            tick();
            if (c >= 1) begin
                check_wr("burst", c - 1, 8'(8'h10 + c - 1));
            end else begin
                check("burst_lat", 32'(fb_wr_en), 32'd0);
            end
        end
        check("drain_ready", 32'(pix_ready), 32'd0);
        check("drain_done_early", 32'(frame_done), 32'd0);
        watch_done(5, 1'b1);
        check("a_done_pulses", 32'(done_cnt), 32'd1);
        check("a_done_nowr", 32'(other_cnt), 32'd0);
        check("a_idle_busy", 32'(busy), 32'd0);
        check("a_px9", 32'(px_count), 32'd9);
        check("a_oob_keep", 32'(oob_count), 32'd2);
        exp_bank = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
        check("a_disp_bank", 32'(disp_bank), 32'd0);
`endif

        // Frame B: reset in the middle of the clear
        gpu_frame_end = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick(); tick(); tick();
        check_wr("b_clr3", 3, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_bank = 1'b0;
        check("b_rst_en", 32'(fb_wr_en), 32'd0);
        check("b_rst_busy", 32'(busy), 32'd0);
        check("b_rst_ready", 32'(pix_ready), 32'd0);
        check("b_rst_px", 32'(px_count), 32'd0);
        check("b_rst_oob", 32'(oob_count), 32'd0);
`ifdef FB_DOUBLE_BUFFER_EN
        check("b_rst_disp_bank", 32'(disp_bank), 32'd1);
`endif
        tick();
        check("b_idle_en", 32'(fb_wr_en), 32'd0);

        // Frame C: restart at 0, ignore frame_start mid-clear, sticky frame_end during clear
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_wr("c_clr", i, 8'h00);
            check("c_clr_ready", 32'(pix_ready), 32'd0);
            if (i == 2) frame_start = 1'b1;
            if (i == 4) gpu_frame_end = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        check("c_exit_en", 32'(fb_wr_en), 32'd0);
        check("c_exit_ready", 32'(pix_ready), 32'd0);
        watch_done(5, 1'b0);
        check("c_done_pulses", 32'(done_cnt), 32'd1);
        check("c_never_ready", 32'(other_cnt), 32'd0);
        check("c_idle_busy", 32'(busy), 32'd0);
        exp_bank = 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
        check("c_disp_bank", 32'(disp_bank), 32'd0);
`endif

        // Frame D: zero width skips the clear; every drawn beat is out of bounds
        gpu_frame_end = 1'b0;
        fb_width = 11'd0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("d_ready", 32'(pix_ready), 32'd1);
        check("d_no_clear", 32'(fb_wr_en), 32'd0);
        check("d_busy", 32'(busy), 32'd1);
        drive_beat(1'b1, 0, 0, 8'h55, 1'b1);
        tick();
        drive_beat(1'b0, 0, 0, 8'h00, 1'b0);
        check("d_oob1", 32'(oob_count), 32'd1);
        gpu_frame_end = 1'b1;
        watch_done(6, 1'b1);
        check("d_done_pulses", 32'(done_cnt), 32'd1);
        check("d_no_writes", 32'(other_cnt), 32'd0);
        check("d_idle_busy", 32'(busy), 32'd0);
        check("d_px0", 32'(px_count), 32'd0);
`ifdef FB_DOUBLE_BUFFER_EN
        check("d_disp_bank", 32'(disp_bank), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
